// File: rtl/axi_sim_memory.sv
// rtl/axi_sim_memory.sv - AXI4 slave memory model with independent read/write burst engines
//
// Purpose: byte-addressed memory `mem` (preload/peek hierarchically) serving
// INCR, FIXED and WRAP bursts; reserved burst type behaves as INCR.
// Ports:
//   clk, rst_n            clock; asynchronous active-high reset
//   aw_* / w_* / b_*      write address, write data, write response channels
//   ar_* / r_*            read address, read data channels
//   mon_w_* / mon_r_*     one-cycle pulse per accepted W beat / issued R beat
module axi_sim_memory #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 1,
  parameter int unsigned USER_WIDTH  = 1,
  parameter bit          WARN_UNINIT = 1'b0,
  parameter int unsigned MEM_AW      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [7:0]              aw_len,
  input  logic [2:0]              aw_size,
  input  logic [1:0]              aw_burst,
  input  logic [USER_WIDTH-1:0]   aw_user,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  input  logic [USER_WIDTH-1:0]   w_user,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  output logic [USER_WIDTH-1:0]   b_user,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic [ID_WIDTH-1:0]     ar_id,
  input  logic [7:0]              ar_len,
  input  logic [2:0]              ar_size,
  input  logic [1:0]              ar_burst,
  input  logic [USER_WIDTH-1:0]   ar_user,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [ID_WIDTH-1:0]     r_id,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic [USER_WIDTH-1:0]   r_user,
  output logic                    mon_w_valid,
  output logic [ADDR_WIDTH-1:0]   mon_w_addr,
  output logic [DATA_WIDTH-1:0]   mon_w_data,
  output logic [ID_WIDTH-1:0]     mon_w_id,
  output logic [USER_WIDTH-1:0]   mon_w_user,
  output logic [7:0]              mon_w_beat_count,
  output logic                    mon_w_last,
  output logic                    mon_r_valid,
  output logic [ADDR_WIDTH-1:0]   mon_r_addr,
  output logic [DATA_WIDTH-1:0]   mon_r_data,
  output logic [ID_WIDTH-1:0]     mon_r_id,
  output logic [USER_WIDTH-1:0]   mon_r_user,
  output logic [7:0]              mon_r_beat_count,
  output logic                    mon_r_last
);

  localparam int unsigned STRB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  logic [7:0] mem  [0:(2**MEM_AW)-1];
  logic       seen [0:(2**MEM_AW)-1];

  function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [2:0] size);
    return a & ~((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1));
  endfunction

  // WRAP relies on len+1 being a power of two, so the window mask is exact.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wmask;
    step  = ADDR_WIDTH'(1) << size;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~wmask) | ((a + step) & wmask);
      default: return a + step;
    endcase
  endfunction

  // ---------------- write path state ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [7:0]            aw_len_q, aw_len_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic [USER_WIDTH-1:0] aw_user_q, aw_user_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  aw_ready_q, aw_ready_d;
  logic                  w_ready_q, w_ready_d;
  logic                  b_valid_q, b_valid_d;
  logic                  mw_valid_q, mw_valid_d;
  logic [ADDR_WIDTH-1:0] mw_addr_q, mw_addr_d;
  logic [DATA_WIDTH-1:0] mw_data_q, mw_data_d;
  logic [ID_WIDTH-1:0]   mw_id_q, mw_id_d;
  logic [USER_WIDTH-1:0] mw_user_q, mw_user_d;
  logic [7:0]            mw_cnt_q, mw_cnt_d;
  logic                  mw_last_q, mw_last_d;

  logic w_fire, w_end;
  assign w_fire = w_valid & w_ready_q;
  assign w_end  = w_last | (w_cnt_q == aw_len_q);

  always_comb begin
    w_state_d  = w_state_q;
    wr_addr_d  = wr_addr_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    aw_user_d  = aw_user_q;
    w_cnt_d    = w_cnt_q;
    mw_valid_d = 1'b0;
    mw_addr_d  = mw_addr_q;
    mw_data_d  = mw_data_q;
    mw_id_d    = mw_id_q;
    mw_user_d  = mw_user_q;
    mw_cnt_d   = mw_cnt_q;
    mw_last_d  = mw_last_q;
    case (w_state_q)
      W_IDLE: if (aw_valid && aw_ready_q) begin
        wr_addr_d  = align(aw_addr, aw_size);
        aw_id_d    = aw_id;
        aw_len_d   = aw_len;
        aw_size_d  = aw_size;
        aw_burst_d = aw_burst;
        aw_user_d  = aw_user;
        w_cnt_d    = 8'd0;
        w_state_d  = W_DATA;
      end
      W_DATA: if (w_fire) begin
        mw_valid_d = 1'b1;
        mw_addr_d  = wr_addr_q;
        mw_data_d  = w_data;
        mw_id_d    = aw_id_q;
        mw_user_d  = w_user;
        mw_cnt_d   = w_cnt_q;
        mw_last_d  = w_end;
        w_cnt_d    = w_cnt_q + 8'd1;
        wr_addr_d  = next_addr(wr_addr_q, aw_len_q, aw_size_q, aw_burst_q);
        if (w_end) w_state_d = W_RESP;
      end
      W_RESP: if (b_ready && b_valid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
    w_ready_d  = (w_state_d == W_DATA);
    b_valid_d  = (w_state_d == W_RESP);
  end

  // ---------------- read path state ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [7:0]            ar_len_q, ar_len_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic [USER_WIDTH-1:0] ar_user_q, ar_user_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  ar_ready_q, ar_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_last_q, r_last_d;
  logic                  mr_valid_q, mr_valid_d;
  logic [ADDR_WIDTH-1:0] mr_addr_q, mr_addr_d;
  logic [DATA_WIDTH-1:0] mr_data_q, mr_data_d;
  logic [7:0]            mr_cnt_q, mr_cnt_d;
  logic                  mr_last_q, mr_last_d;

  logic                  r_fire;
  logic                  r_fetch;
  logic [ADDR_WIDTH-1:0] r_fetch_addr;
  logic [MEM_AW-1:0]     r_fetch_base;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic [MEM_AW-1:0]     w_base;

  assign r_fire       = r_valid_q & r_ready;
  assign r_fetch_base = r_fetch_addr[MEM_AW-1:0] & ~MEM_AW'(STRB - 1);
  assign w_base       = wr_addr_q[MEM_AW-1:0] & ~MEM_AW'(STRB - 1);

  // Address of the beat whose data must be loaded into r_data at this edge.
  always_comb begin
    r_fetch      = 1'b0;
    r_fetch_addr = rd_addr_q;
    if (r_state_q == R_IDLE && ar_valid && ar_ready_q) begin
      r_fetch      = 1'b1;
      r_fetch_addr = align(ar_addr, ar_size);
    end else if (r_state_q == R_DATA && r_fire && !r_last_q) begin
      r_fetch      = 1'b1;
      r_fetch_addr = next_addr(rd_addr_q, ar_len_q, ar_size_q, ar_burst_q);
    end
  end

  // Sampled before this edge's write commits, so a same-cycle write is not seen.
  always_comb begin
    r_fetch_data = '0;
    for (int i = 0; i < int'(STRB); i++)
      r_fetch_data[8*i +: 8] = mem[r_fetch_base + MEM_AW'(i)];
  end

  always_comb begin
    r_state_d  = r_state_q;
    rd_addr_d  = rd_addr_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    ar_user_d  = ar_user_q;
    r_cnt_d    = r_cnt_q;
    r_data_d   = r_data_q;
    r_last_d   = r_last_q;
    mr_valid_d = 1'b0;
    mr_addr_d  = mr_addr_q;
    mr_data_d  = mr_data_q;
    mr_cnt_d   = mr_cnt_q;
    mr_last_d  = mr_last_q;
    case (r_state_q)
      R_IDLE: if (ar_valid && ar_ready_q) begin
        rd_addr_d  = r_fetch_addr;
        ar_id_d    = ar_id;
        ar_len_d   = ar_len;
        ar_size_d  = ar_size;
        ar_burst_d = ar_burst;
        ar_user_d  = ar_user;
        r_cnt_d    = 8'd0;
        r_data_d   = r_fetch_data;
        r_last_d   = (ar_len == 8'd0);
        r_state_d  = R_DATA;
      end
      R_DATA: if (r_fire) begin
        mr_valid_d = 1'b1;
        mr_addr_d  = rd_addr_q;
        mr_data_d  = r_data_q;
        mr_cnt_d   = r_cnt_q;
        mr_last_d  = r_last_q;
        if (r_last_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d   = r_cnt_q + 8'd1;
          rd_addr_d = r_fetch_addr;
          r_data_d  = r_fetch_data;
          r_last_d  = ((r_cnt_q + 8'd1) == ar_len_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      w_state_q  <= W_IDLE;
      wr_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_user_q  <= '0;
      w_cnt_q    <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      mw_valid_q <= 1'b0;
      mw_addr_q  <= '0;
      mw_data_q  <= '0;
      mw_id_q    <= '0;
      mw_user_q  <= '0;
      mw_cnt_q   <= '0;
      mw_last_q  <= 1'b0;
      r_state_q  <= R_IDLE;
      rd_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_user_q  <= '0;
      r_cnt_q    <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_last_q   <= 1'b0;
      mr_valid_q <= 1'b0;
      mr_addr_q  <= '0;
      mr_data_q  <= '0;
      mr_cnt_q   <= '0;
      mr_last_q  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      wr_addr_q  <= wr_addr_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      aw_user_q  <= aw_user_d;
      w_cnt_q    <= w_cnt_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      mw_valid_q <= mw_valid_d;
      mw_addr_q  <= mw_addr_d;
      mw_data_q  <= mw_data_d;
      mw_id_q    <= mw_id_d;
      mw_user_q  <= mw_user_d;
      mw_cnt_q   <= mw_cnt_d;
      mw_last_q  <= mw_last_d;
      r_state_q  <= r_state_d;
      rd_addr_q  <= rd_addr_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      ar_user_q  <= ar_user_d;
      r_cnt_q    <= r_cnt_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_last_q   <= r_last_d;
      mr_valid_q <= mr_valid_d;
      mr_addr_q  <= mr_addr_d;
      mr_data_q  <= mr_data_d;
      mr_cnt_q   <= mr_cnt_d;
      mr_last_q  <= mr_last_d;
    end
  end

  // Storage is never reset so backdoor preloads survive reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int i = 0; i < int'(STRB); i++) begin
        if (w_strb[i]) begin
          mem[w_base + MEM_AW'(i)]  <= w_data[8*i +: 8];
          seen[w_base + MEM_AW'(i)] <= 1'b1;
        end
      end
    end
    if (WARN_UNINIT && r_fetch) begin
      for (int i = 0; i < int'(STRB); i++)
        if (!seen[r_fetch_base + MEM_AW'(i)])
          $warning("axi_sim_memory: read of unwritten byte %h", r_fetch_base + MEM_AW'(i));
    end
  end

  assign aw_ready         = aw_ready_q;
  assign w_ready          = w_ready_q;
  assign b_valid          = b_valid_q;
  assign b_id             = aw_id_q;
  assign b_resp           = 2'b00;
  assign b_user           = aw_user_q;
  assign ar_ready         = ar_ready_q;
  assign r_valid          = r_valid_q;
  assign r_data           = r_data_q;
  assign r_id             = ar_id_q;
  assign r_resp           = 2'b00;
  assign r_last           = r_last_q;
  assign r_user           = ar_user_q;
  assign mon_w_valid      = mw_valid_q;
  assign mon_w_addr       = mw_addr_q;
  assign mon_w_data       = mw_data_q;
  assign mon_w_id         = mw_id_q;
  assign mon_w_user       = mw_user_q;
  assign mon_w_beat_count = mw_cnt_q;
  assign mon_w_last       = mw_last_q;
  assign mon_r_valid      = mr_valid_q;
  assign mon_r_addr       = mr_addr_q;
  assign mon_r_data       = mr_data_q;
  assign mon_r_id         = ar_id_q;
  assign mon_r_user       = ar_user_q;
  assign mon_r_beat_count = mr_cnt_q;
  assign mon_r_last       = mr_last_q;

endmodule

// File: tb/tb_axi_sim_memory.sv
// tb/tb_axi_sim_memory.sv - scoreboard bench for axi_sim_memory
module tb_axi_sim_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic        aw_id;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_user;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last, w_user;
  logic        b_valid, b_ready, b_id, b_user;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic        ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_user;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic        r_id, r_last, r_user;
  logic [1:0]  r_resp;
  logic        mon_w_valid, mon_w_id, mon_w_user, mon_w_last;
  logic [31:0] mon_w_addr, mon_w_data;
  logic [7:0]  mon_w_beat_count;
  logic        mon_r_valid, mon_r_id, mon_r_user, mon_r_last;
  logic [31:0] mon_r_addr, mon_r_data;
  logic [7:0]  mon_r_beat_count;

  axi_sim_memory dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_user(aw_user),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .w_last(w_last), .w_user(w_user),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_user(ar_user),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
    .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
    .mon_w_valid(mon_w_valid), .mon_w_addr(mon_w_addr), .mon_w_data(mon_w_data),
    .mon_w_id(mon_w_id), .mon_w_user(mon_w_user), .mon_w_beat_count(mon_w_beat_count),
    .mon_w_last(mon_w_last),
    .mon_r_valid(mon_r_valid), .mon_r_addr(mon_r_addr), .mon_r_data(mon_r_data),
    .mon_r_id(mon_r_id), .mon_r_user(mon_r_user), .mon_r_beat_count(mon_r_beat_count),
    .mon_r_last(mon_r_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  cnt;
    logic        last;
    logic        id;
  } exp_t;

  exp_t q_r[$];
  exp_t q_mw[$];
  exp_t q_mr[$];
  logic q_b[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wd[8], wa[8], rdat[8], ra[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (b_valid && b_ready) begin
      if (q_b.size() == 0) chk("b_unexpected", 64'(q_b.size()), 64'd1);
      else begin
        chk("b_id", 64'(b_id), 64'(q_b.pop_front()));
        chk("b_resp", 64'(b_resp), 64'd0);
      end
    end
    if (r_valid && r_ready) begin
      if (q_r.size() == 0) chk("r_unexpected", 64'(q_r.size()), 64'd1);
      else begin
        e = q_r.pop_front();
        chk("r_data", 64'(r_data), 64'(e.data));
        chk("r_last", 64'(r_last), 64'(e.last));
        chk("r_id", 64'(r_id), 64'(e.id));
        chk("r_resp", 64'(r_resp), 64'd0);
      end
    end
    if (mon_w_valid) begin
      if (q_mw.size() == 0) chk("mon_w_unexpected", 64'(q_mw.size()), 64'd1);
      else begin
        e = q_mw.pop_front();
        chk("mon_w_addr", 64'(mon_w_addr), 64'(e.addr));
        chk("mon_w_data", 64'(mon_w_data), 64'(e.data));
        chk("mon_w_beat_count", 64'(mon_w_beat_count), 64'(e.cnt));
        chk("mon_w_last", 64'(mon_w_last), 64'(e.last));
        chk("mon_w_id", 64'(mon_w_id), 64'(e.id));
      end
    end
    if (mon_r_valid) begin
      if (q_mr.size() == 0) chk("mon_r_unexpected", 64'(q_mr.size()), 64'd1);
      else begin
        e = q_mr.pop_front();
        chk("mon_r_addr", 64'(mon_r_addr), 64'(e.addr));
        chk("mon_r_data", 64'(mon_r_data), 64'(e.data));
        chk("mon_r_beat_count", 64'(mon_r_beat_count), 64'(e.cnt));
        chk("mon_r_last", 64'(mon_r_last), 64'(e.last));
      end
    end
  end

  task automatic axi_wr(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                        input logic [1:0] burst, input logic id, input logic [3:0] strb,
                        input bit abandon);
    int n;
    bit hs;
    exp_t e;
    if (!abandon) q_b.push_back(id);
    for (int b = 0; b < nbeats; b++) begin
      e = '{wa[b], wd[b], 8'(b), (b == nbeats - 1) && !abandon, id};
      q_mw.push_back(e);
    end
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len;
    aw_size = 3'd2; aw_burst = burst;
    n = 0;
    do begin
      @(negedge clk); hs = aw_ready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    if (!hs) chk("aw_timeout", 64'(hs), 64'd1);
    aw_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      w_valid = 1'b1; w_data = wd[b]; w_strb = strb;
      w_last = (b == nbeats - 1) && !abandon;
      n = 0;
      do begin
        @(negedge clk); hs = w_ready;
        @(posedge clk); #1; n++;
      end while (!hs && n < 50);
      if (!hs) chk("w_timeout", 64'(hs), 64'd1);
    end
    w_valid = 1'b0; w_last = 1'b0;
    if (!abandon) begin
      n = 0;
      do begin
        @(negedge clk); hs = b_valid;
        @(posedge clk); #1; n++;
      end while (!hs && n < 50);
      if (!hs) chk("b_timeout", 64'(hs), 64'd1);
    end
  endtask

  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic id);
    int n;
    bit hs;
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len;
    ar_size = 3'd2; ar_burst = burst;
    n = 0;
    do begin
      @(negedge clk); hs = ar_ready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    if (!hs) chk("ar_timeout", 64'(hs), 64'd1);
    ar_valid = 1'b0;
  endtask

  task automatic axi_rd(input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic id, input int hold);
    int n, got;
    exp_t e;
    for (int b = 0; b <= int'(len); b++) begin
      e = '{ra[b], rdat[b], 8'(b), (b == int'(len)), id};
      q_r.push_back(e);
      q_mr.push_back(e);
    end
    r_ready = (hold == 0);
    ar_issue(addr, len, burst, id);
    if (hold > 0) begin
      n = 0;
      while (!r_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("r_hold_valid", 64'(r_valid), 64'd1);
        chk("r_hold_data", 64'(r_data), 64'(rdat[0]));
        @(posedge clk); #1;
      end
      r_ready = 1'b1;
    end
    got = 0; n = 0;
    do begin
      @(negedge clk); if (r_valid && r_ready) got++;
      @(posedge clk); #1; n++;
    end while (got < int'(len) + 1 && n < 100);
    if (got != int'(len) + 1) chk("r_beats", 64'(got), 64'(len) + 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_user = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; w_user = 0;
    b_ready = 1;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_user = 0;
    r_ready = 1;
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_valids", 64'({w_ready, b_valid, r_valid, mon_w_valid, mon_r_valid}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_aw_ready", 64'(aw_ready), 64'd1);
    chk("post_rst_ar_ready", 64'(ar_ready), 64'd1);
    @(posedge clk); #1;

    // single write + read + peek
    wd[0] = 32'hDEADBEEF; wa[0] = 32'h100;
    axi_wr(32'h100, 8'd0, 1, 2'b01, 1'b0, 4'hF, 1'b0);
    chk("peek_100", 64'(dut.mem[16'h0100]), 64'hEF);
    rdat[0] = 32'hDEADBEEF; ra[0] = 32'h100;
    axi_rd(32'h100, 8'd0, 2'b01, 1'b0, 0);

    // INCR burst of 4
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); wa[i] = 32'h200 + 32'(4 * i);
      rdat[i] = wd[i]; ra[i] = wa[i];
    end
    axi_wr(32'h200, 8'd3, 4, 2'b01, 1'b1, 4'hF, 1'b0);
    axi_rd(32'h200, 8'd3, 2'b01, 1'b1, 0);

    // strobe merge
    wd[0] = 32'h11223344; wa[0] = 32'h300;
    axi_wr(32'h300, 8'd0, 1, 2'b01, 1'b0, 4'hF, 1'b0);
    wd[0] = 32'hAABBCCDD;
    axi_wr(32'h300, 8'd0, 1, 2'b01, 1'b0, 4'b0101, 1'b0);
    rdat[0] = 32'h11BB33DD; ra[0] = 32'h300;
    axi_rd(32'h300, 8'd0, 2'b01, 1'b0, 0);

    // WRAP read from 0x108 over a 16-byte window
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'h10 + 32'(i); wa[i] = 32'h100 + 32'(4 * i);
    end
    axi_wr(32'h100, 8'd3, 4, 2'b01, 1'b0, 4'hF, 1'b0);
    ra[0] = 32'h108; ra[1] = 32'h10C; ra[2] = 32'h100; ra[3] = 32'h104;
    rdat[0] = 32'h12; rdat[1] = 32'h13; rdat[2] = 32'h10; rdat[3] = 32'h11;
    axi_rd(32'h108, 8'd3, 2'b10, 1'b0, 0);

    // FIXED write: both beats land on 0x500
    wd[0] = 32'h5; wd[1] = 32'h6; wa[0] = 32'h500; wa[1] = 32'h500;
    axi_wr(32'h500, 8'd1, 2, 2'b00, 1'b1, 4'hF, 1'b0);
    rdat[0] = 32'h6; ra[0] = 32'h500;
    axi_rd(32'h500, 8'd0, 2'b01, 1'b1, 0);

    // reserved burst type reads as INCR
    rdat[0] = 32'h1; rdat[1] = 32'h2; ra[0] = 32'h200; ra[1] = 32'h204;
    axi_rd(32'h200, 8'd1, 2'b11, 1'b0, 0);

    // early w_last ends a len=3 burst after 2 beats
    wd[0] = 32'h7; wd[1] = 32'h8; wa[0] = 32'h600; wa[1] = 32'h604;
    axi_wr(32'h600, 8'd3, 2, 2'b01, 1'b0, 4'hF, 1'b0);
    rdat[0] = 32'h7; rdat[1] = 32'h8; ra[0] = 32'h600; ra[1] = 32'h604;
    axi_rd(32'h600, 8'd1, 2'b01, 1'b0, 0);

    // backpressure: r_data held for 5 cycles
    for (int i = 0; i < 4; i++) begin
      rdat[i] = 32'(i + 1); ra[i] = 32'h200 + 32'(4 * i);
    end
    axi_rd(32'h200, 8'd3, 2'b01, 1'b1, 5);

    // reset mid-burst on both paths
    wd[0] = 32'h99; wa[0] = 32'h400;
    axi_wr(32'h400, 8'd3, 1, 2'b01, 1'b0, 4'hF, 1'b1);
    r_ready = 1'b0;
    ar_issue(32'h200, 8'd3, 2'b01, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_r_valid", 64'(r_valid), 64'd1);
    chk("mid_w_ready", 64'(w_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valids", 64'({w_ready, b_valid, r_valid, mon_w_valid, mon_r_valid}), 64'd0);
    chk("midrst_readies", 64'({aw_ready, ar_ready}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    r_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_midrst_ready", 64'({aw_ready, ar_ready}), 64'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("peek_300_kept", 64'(dut.mem[16'h0300]), 64'hDD);
    rdat[0] = 32'h1; ra[0] = 32'h200;
    axi_rd(32'h200, 8'd0, 2'b01, 1'b1, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("q_b_empty", 64'(q_b.size()), 64'd0);
    chk("q_r_empty", 64'(q_r.size()), 64'd0);
    chk("q_mw_empty", 64'(q_mw.size()), 64'd0);
    chk("q_mr_empty", 64'(q_mr.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
